// File: rtl/barrel_shift_l_seq.sv
// rtl/barrel_shift_l_seq.sv - multicycle left rotate / logical shift, one log-stage per clock
//
// Purpose: rotates left (mode=0) or shifts left with zero fill (mode=1) a
//          WIDTH-bit operand by shift_amnt, applying one power-of-two stage
//          per clock so the result appears SHW cycles after acceptance.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     producer handshake (accept in IDLE only)
//   shift_amnt [SHW-1:0]    distance 0..WIDTH-1
//   shift_str  [WIDTH-1:0]  operand
//   mode                    0 = rotate left, 1 = shift left zero fill
//   out_valid / out_ready   consumer handshake (result held under backpressure)
//   shifted_str[WIDTH-1:0]  result, holds last value until next completion
//   busy                    high while shifting or waiting for the consumer
module barrel_shift_l_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SHW-1:0]   shift_amnt,
    input  logic [WIDTH-1:0] shift_str,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] shifted_str,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   k_q, k_d;
    logic [SHW-1:0]   amt_q, amt_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] stage_out;

    // Candidate results of every stage, computed from the working register.
    // Only the one selected by k is ever committed.
    logic [WIDTH-1:0] stage_rot [SHW];
    logic [WIDTH-1:0] stage_shl [SHW];

    for (genvar g = 0; g < SHW; g++) begin : g_stage
        localparam int D = 2 ** g;
        assign stage_rot[g] = {work_q[WIDTH-1-D:0], work_q[WIDTH-1:WIDTH-D]};
        assign stage_shl[g] = {work_q[WIDTH-1-D:0], {D{1'b0}}};
    end

    always_comb begin
        stage_out = work_q;
        for (int s = 0; s < SHW; s++) begin
            if ((k_q == SHW'(s)) && amt_q[s]) begin
                stage_out = mode_q ? stage_shl[s] : stage_rot[s];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        amt_d   = amt_q;
        mode_d  = mode_q;
        work_d  = work_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d  = shift_str;
                    amt_d   = shift_amnt;
                    mode_d  = mode;
                    k_d     = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                work_d = stage_out;
                k_d    = k_q + SHW'(1);
                if (k_q == SHW'(SHW - 1)) begin
                    // Result register only changes here, so partial stage
                    // values never reach shifted_str.
                    res_d   = stage_out;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            amt_q   <= '0;
            mode_q  <= 1'b0;
            work_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            amt_q   <= amt_d;
            mode_q  <= mode_d;
            work_q  <= work_d;
            res_q   <= res_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign shifted_str = res_q;

endmodule
